mem_arbiter: RTL and testbench

- Shares one single-ported backing memory between the core's instruction-fetch port (imem) and data port (dmem).
- The core's ControlPath drives both ports and holds each request until the response arrives; this hold is what feeds its cache-miss stall.
- The arbiter grants one port at a time with one outstanding transaction, gives dmem priority with a bounded streak so imem cannot starve, and returns each response to the port that issued it.
- It sits between the core and the memory model / memory controller.

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported backing memory between the core's
// instruction-fetch (imem) and data (dmem) ports. One transaction is in
// flight at a time; dmem wins contention for at most MAX_D_STREAK grants in
// a row while imem waits, and each response returns to the issuing port.
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int ADDR_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_kill,
  output logic              i_res_valid,
  output logic [XLEN-1:0]   i_res_rdata,

  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [XLEN-1:0]   d_req_wdata,
  input  logic              d_req_fcn,
  input  logic [2:0]        d_req_typ,
  output logic              d_res_valid,
  output logic [XLEN-1:0]   d_res_rdata,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic              mem_req_fcn,
  output logic [2:0]        mem_req_typ,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  // Fetches are always full unsigned words.
  localparam logic [2:0] MT_WU = 3'd7;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t              state_q,     state_d;
  owner_t              owner_q,     owner_d;
  logic                kill_q,      kill_d;
  logic [STREAK_W-1:0] streak_q,    streak_d;
  logic [ADDR_W-1:0]   req_addr_q,  req_addr_d;
  logic [XLEN-1:0]     req_wdata_q, req_wdata_d;
  logic                req_fcn_q,   req_fcn_d;
  logic [2:0]          req_typ_q,   req_typ_d;
  logic [XLEN-1:0]     rdata_q,     rdata_d;

  // State and request/response registers; reset clears everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      kill_q      <= 1'b0;
      streak_q    <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_fcn_q   <= 1'b0;
      req_typ_q   <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      kill_q      <= kill_d;
      streak_q    <= streak_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_fcn_q   <= req_fcn_d;
      req_typ_q   <= req_typ_d;
      rdata_q     <= rdata_d;
    end
  end

  // Arbitration, transaction sequencing and kill tracking.
  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path through
    // the case statement leaves one unassigned (which would infer a latch).
    state_d     = state_q;
    owner_d     = owner_q;
    kill_d      = kill_q;
    streak_d    = streak_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_fcn_d   = req_fcn_q;
    req_typ_d   = req_typ_q;
    rdata_d     = rdata_q;

    // A squash of the in-flight fetch lets memory finish but hides the result.
    if (state_q != IDLE && owner_q == OWN_I && i_kill) begin
      kill_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (d_req_valid && (!i_req_valid || streak_q != STREAK_MAX)) begin
          state_d     = ISSUE;
          owner_d     = OWN_D;
          req_addr_d  = d_req_addr;
          req_wdata_d = d_req_wdata;
          req_fcn_d   = d_req_fcn;
          req_typ_d   = d_req_typ;
          // The streak only counts grants that made imem wait.
          if (!i_req_valid) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (i_req_valid && !i_kill) begin
          state_d     = ISSUE;
          owner_d     = OWN_I;
          req_addr_d  = i_req_addr;
          req_wdata_d = '0;
          req_fcn_d   = 1'b0;
          req_typ_d   = MT_WU;
          streak_d    = '0;
        end
      end
      ISSUE: begin
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          rdata_d = mem_resp_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; no input reaches an output.
  assign mem_req_valid = (state_q == ISSUE);
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_fcn   = req_fcn_q;
  assign mem_req_typ   = req_typ_q;
  assign i_res_valid   = (state_q == RESP) && (owner_q == OWN_I) && !kill_q;
  assign d_res_valid   = (state_q == RESP) && (owner_q == OWN_D);
  assign i_res_rdata   = rdata_q;
  assign d_res_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a behavioural backing-memory model with
// programmable ready/response delays, a transaction-level response predictor
// compared every cycle, and directed scenarios with hand-computed literals.
module tb_mem_arbiter;

  localparam int XLEN = 32;
  localparam int ADDR_W = 32;
  localparam logic [2:0] MT_WU = 3'd7;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              i_req_valid = 1'b0;
  logic [ADDR_W-1:0] i_req_addr = '0;
  logic              i_kill = 1'b0;
  logic              i_res_valid;
  logic [XLEN-1:0]   i_res_rdata;
  logic              d_req_valid = 1'b0;
  logic [ADDR_W-1:0] d_req_addr = '0;
  logic [XLEN-1:0]   d_req_wdata = '0;
  logic              d_req_fcn = 1'b0;
  logic [2:0]        d_req_typ = '0;
  logic              d_res_valid;
  logic [XLEN-1:0]   d_res_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [XLEN-1:0]   mem_req_wdata;
  logic              mem_req_fcn;
  logic [2:0]        mem_req_typ;
  logic              mem_resp_valid = 1'b0;
  logic [XLEN-1:0]   mem_resp_rdata = '0;

  mem_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MAX_D_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_kill(i_kill),
    .i_res_valid(i_res_valid), .i_res_rdata(i_res_rdata),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_req_fcn(d_req_fcn), .d_req_typ(d_req_typ),
    .d_res_valid(d_res_valid), .d_res_rdata(d_res_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_fcn(mem_req_fcn), .mem_req_typ(mem_req_typ),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'bx;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] data_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  // Memory model configuration.
  int          ready_delay = 0;
  int          resp_delay = 0;
  bit          fixed_en = 1'b0;
  logic [31:0] fixed_data = '0;

  // Memory model / predictor state. Owner: 0 = imem, 1 = dmem.
  int          phase = 0;
  int          cnt = 0;
  bit          late_inject = 1'b0;
  logic [31:0] s_addr, s_wdata;
  logic        s_fcn;
  logic [2:0]  s_typ;
  int          cur_owner = 0;
  bit          cur_killed = 1'b0;
  bit          pend = 1'b0;
  int          pend_owner = 0;
  bit          pend_killed = 1'b0;
  logic [31:0] pend_data = '0;
  int          grant_q[$];
  int          first_req_cyc = 0;
  int          i_res_cnt = 0;
  int          d_res_cnt = 0;

  // Compare DUT outputs against the predictor, then advance the memory model
  // and drive its inputs for the coming rising edge.
  always @(negedge clk) begin
    if (rst_seen !== 1'bx) begin
      if (rst_seen == 1'b0) begin
        check("rst_valids", {61'd0, mem_req_valid, i_res_valid, d_res_valid}, 64'd0);
        check("rst_req_addr", mem_req_addr, 64'd0);
        check("rst_req_wdata", mem_req_wdata, 64'd0);
        check("rst_req_fcn_typ", {mem_req_fcn, mem_req_typ}, 64'd0);
        check("rst_rdata", {i_res_rdata, d_res_rdata}, 64'd0);
      end else begin
        check("i_res_valid", i_res_valid, pend && pend_owner == 0 && !pend_killed);
        check("d_res_valid", d_res_valid, pend && pend_owner == 1);
        if (pend && pend_owner == 1) check("d_res_rdata", d_res_rdata, pend_data);
        if (pend && pend_owner == 0 && !pend_killed) check("i_res_rdata", i_res_rdata, pend_data);
        if (phase == 1) begin
          check("req_held", mem_req_valid, 1'b1);
          check("req_addr_stable", mem_req_addr, s_addr);
          check("req_wdata_stable", mem_req_wdata, s_wdata);
          check("req_fcn_typ_stable", {mem_req_fcn, mem_req_typ}, {s_fcn, s_typ});
        end
        if (phase == 2 || pend) check("one_outstanding", mem_req_valid, 1'b0);
      end
      if (i_res_valid === 1'b1) i_res_cnt++;
      if (d_res_valid === 1'b1) d_res_cnt++;
    end

    pend           = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    if (reset == 1'b0) begin
      late_inject = (phase == 2);
      phase = 0;
      cnt   = 0;
    end else if (late_inject) begin
      // Stale response from a transaction abandoned by reset.
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 32'hBAD0BAD0;
      late_inject    = 1'b0;
    end else begin
      if (phase == 0 && mem_req_valid === 1'b1) begin
        s_addr = mem_req_addr; s_wdata = mem_req_wdata;
        s_fcn  = mem_req_fcn;  s_typ   = mem_req_typ;
        if (d_req_valid && mem_req_addr == d_req_addr && mem_req_fcn == d_req_fcn &&
            mem_req_typ == d_req_typ && (!d_req_fcn || mem_req_wdata == d_req_wdata))
          cur_owner = 1;
        else if (i_req_valid && mem_req_addr == i_req_addr && !mem_req_fcn && mem_req_typ == MT_WU)
          cur_owner = 0;
        else begin
          cur_owner = 2;
          check("req_source_addr", mem_req_addr, d_req_valid ? d_req_addr : i_req_addr);
        end
        grant_q.push_back(cur_owner);
        first_req_cyc = cyc;
        cur_killed = 1'b0;
        phase = 1;
        cnt = 0;
      end
      if ((phase == 1 || phase == 2) && cur_owner == 0 && i_kill) cur_killed = 1'b1;
      if (phase == 1) begin
        if (cnt == ready_delay) begin
          mem_req_ready = 1'b1;
          phase = 2;
          cnt = 0;
        end else cnt++;
      end else if (phase == 2) begin
        if (cnt == resp_delay) begin
          pend_data      = fixed_en ? fixed_data : data_fn(s_addr);
          mem_resp_valid = 1'b1;
          mem_resp_rdata = pend_data;
          pend        = 1'b1;
          pend_owner  = cur_owner;
          pend_killed = cur_killed;
          phase = 0;
        end else cnt++;
      end
    end
  end

  // Issue one dmem request and wait for its response pulse.
  task automatic d_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic fcn,
                       input logic [2:0] typ, output int c0, output int lat,
                       output logic [31:0] rdata);
    d_req_valid = 1'b1; d_req_addr = addr; d_req_wdata = wdata;
    d_req_fcn = fcn; d_req_typ = typ;
    c0 = cyc; lat = -1; rdata = '0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (d_res_valid) begin lat = cyc - c0; rdata = d_res_rdata; break; end
    end
    d_req_valid = 1'b0;
    if (lat < 0) check("d_txn_timeout", d_res_valid, 1'b1);
    @(posedge clk); #1;
    check("d_res_single_pulse", d_res_valid, 1'b0);
  endtask

  task automatic i_txn(input logic [31:0] addr, output int lat, output logic [31:0] rdata);
    int c0;
    i_req_valid = 1'b1; i_req_addr = addr;
    c0 = cyc; lat = -1; rdata = '0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (i_res_valid) begin lat = cyc - c0; rdata = i_res_rdata; break; end
    end
    i_req_valid = 1'b0;
    if (lat < 0) check("i_txn_timeout", i_res_valid, 1'b1);
    @(posedge clk); #1;
    check("i_res_single_pulse", i_res_valid, 1'b0);
  endtask

  int exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    int c0, lat, icnt, dcnt;
    logic [31:0] rd;

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single dmem read, zero-wait memory.
    ready_delay = 0; resp_delay = 0; fixed_en = 1'b1; fixed_data = 32'hDEADBEEF;
    icnt = i_res_cnt;
    d_txn(32'h100, 32'h0, 1'b0, 3'd3, c0, lat, rd);
    check("rd_req_cycle", first_req_cyc - c0, 1);
    check("rd_latency", lat, 3);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_no_imem_res", i_res_cnt - icnt, 0);

    // Imem fetch with ready and response stalls.
    ready_delay = 2; resp_delay = 2; fixed_en = 1'b0;
    i_txn(32'h80, lat, rd);
    check("if_latency", lat, 7);
    check("if_typ_wu", s_typ, MT_WU);
    check("if_data", rd, 32'hC325FF7F);

    // Dmem write.
    ready_delay = 0; resp_delay = 0;
    dcnt = d_res_cnt;
    d_txn(32'h40, 32'h12345678, 1'b1, 3'd3, c0, lat, rd);
    check("wr_mem_fields", {s_fcn, s_typ, s_addr},
          {1'b1, 3'd3, 32'h40});
    check("wr_mem_wdata", s_wdata, 32'h12345678);
    check("wr_latency", lat, 3);
    check("wr_res_count", d_res_cnt - dcnt, 1);

    // Contention: both ports request continuously.
    grant_q.delete();
    fork
      begin : d_stream
        bit seen;
        for (int n = 0; n < 8; n++) begin
          d_req_valid = 1'b1; d_req_addr = 32'h1000 + 32'(4 * n);
          d_req_fcn = 1'b0; d_req_typ = 3'd3;
          seen = 1'b0;
          for (int k = 0; k < 200 && !seen; k++) begin
            @(posedge clk); #1;
            seen = d_res_valid;
          end
          if (!seen) check("cont_d_timeout", d_res_valid, 1'b1);
        end
        d_req_valid = 1'b0;
      end
      begin : i_stream
        bit seen;
        for (int n = 0; n < 2; n++) begin
          i_req_valid = 1'b1; i_req_addr = 32'h200 + 32'(4 * n);
          seen = 1'b0;
          for (int k = 0; k < 200 && !seen; k++) begin
            @(posedge clk); #1;
            seen = i_res_valid;
          end
          if (!seen) check("cont_i_timeout", i_res_valid, 1'b1);
        end
        i_req_valid = 1'b0;
      end
    join
    @(posedge clk); #1;
    check("cont_grant_count", grant_q.size(), 10);
    for (int g = 0; g < 10 && g < grant_q.size(); g++)
      check($sformatf("cont_grant_%0d", g), grant_q[g], exp_order[g]);

    // Kill during WAIT, with a dmem request arriving meanwhile.
    ready_delay = 0; resp_delay = 3;
    grant_q.delete();
    icnt = i_res_cnt; dcnt = d_res_cnt;
    i_req_valid = 1'b1; i_req_addr = 32'h300;
    repeat (2) @(posedge clk);
    #1 i_kill = 1'b1;
    d_req_valid = 1'b1; d_req_addr = 32'h1100; d_req_fcn = 1'b0; d_req_typ = 3'd2;
    @(posedge clk);
    #1 i_kill = 1'b0; i_req_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (d_res_valid) begin lat = k; break; end
    end
    d_req_valid = 1'b0;
    if (lat < 0) check("kill_d_timeout", d_res_valid, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("kill_no_imem_res", i_res_cnt - icnt, 0);
    check("kill_d_res", d_res_cnt - dcnt, 1);
    check("kill_grants", grant_q.size(), 2);
    if (grant_q.size() == 2) check("kill_next_is_d", grant_q[1], 1);

    // Reset for one cycle mid-WAIT, then a late memory response.
    ready_delay = 0; resp_delay = 3;
    icnt = i_res_cnt; dcnt = d_res_cnt;
    d_req_valid = 1'b1; d_req_addr = 32'h1200; d_req_fcn = 1'b0; d_req_typ = 3'd3;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; d_req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rstmid_no_res", (i_res_cnt - icnt) + (d_res_cnt - dcnt), 0);
    resp_delay = 0; fixed_en = 1'b1; fixed_data = 32'hCAFEF00D;
    d_txn(32'h1204, 32'h0, 1'b0, 3'd3, c0, lat, rd);
    check("rstmid_after_latency", lat, 3);
    check("rstmid_after_data", rd, 32'hCAFEF00D);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
